// File: rtl/shift_sched_pkg.sv
// Shared types and defaults for the shift-enable scheduler.
// Op encoding, FSM states and default widths.
package shift_sched_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int LEN_W_DEF = 7;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_RUN   = 2'b01,
    OP_BURST = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10,
    S_FLUSH = 2'b11
  } state_e;

endpackage

// File: rtl/tick_timer.sv
// Loadable period down-counter with zero flag.
// Reloads the latched period automatically when it hits zero.
module tick_timer
  import shift_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
    end else if (load) begin
      cnt    <= load_val;
      period <= load_val;
    end else if (en) begin
      cnt <= zero ? period : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/shift_tick_sched.sv
// Shift-enable scheduler: free-run, burst, flush and stop
// commands over a valid/ready port drive a DEPTH-stage chain.
module shift_tick_sched
  import shift_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 100,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             shift_en,
  output logic             flush,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] tick_cnt
);

  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LAST = LEN_W'(DEPTH - 1);

  state_e           state;
  op_e              op;
  logic [LEN_W-1:0] len_q;
  logic             done_q;
  logic             zero_pend;
  logic             accept;
  logic             timed;
  logic             zero;
  logic             tick;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign timed     = (state == S_RUN) || (state == S_BURST);
  assign tick      = timed && zero;
  assign shift_en  = tick || (state == S_FLUSH);
  assign flush     = (state == S_FLUSH);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cmd_period),
    .en       (timed),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      // A zero-length burst reports done one cycle after accept.
      done_q    <= zero_pend;
      zero_pend <= 1'b0;
      if (accept) begin
        tick_cnt <= '0;
        len_q    <= cmd_len;
        unique case (1'b1)
          (op == OP_STOP):  state <= S_IDLE;
          (op == OP_RUN):   state <= S_RUN;
          (op == OP_FLUSH): state <= S_FLUSH;
          (op == OP_BURST): begin
            if (cmd_len == '0) begin
              state     <= S_IDLE;
              zero_pend <= 1'b1;
            end else begin
              state <= S_BURST;
            end
          end
        endcase
      end else begin
        unique case (1'b1)
          (state == S_RUN): begin
            if (tick) tick_cnt <= tick_cnt + ONE;
          end
          (state == S_BURST): begin
            if (tick) begin
              tick_cnt <= tick_cnt + ONE;
              if (tick_cnt + ONE == len_q) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end
            end
          end
          (state == S_FLUSH): begin
            tick_cnt <= tick_cnt + ONE;
            if (tick_cnt == LAST) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_tick_sched.sv
// Directed bench for shift_tick_sched.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_tick_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_period = 4'd0;
  logic [6:0] cmd_len = 7'd0;
  logic       shift_en;
  logic       flush;
  logic       busy;
  logic       done;
  logic [6:0] tick_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_tick_sched #(.CNT_W(4), .DEPTH(100), .LEN_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_period (cmd_period),
    .cmd_len    (cmd_len),
    .shift_en   (shift_en),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .tick_cnt   (tick_cnt)
  );

  task automatic check(input string tag, input int n,
                       input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // Offer a command now; returns in cycle 0 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] p,
                       input logic [6:0] l);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_period = p;
    cmd_len    = l;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_period = 4'd0;
    cmd_len    = 7'd0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_shift", 0, shift_en, 1'b0);
    check("rst_flush", 0, flush, 1'b0);
    check("rst_busy", 0, busy, 1'b0);
    check("rst_done", 0, done, 1'b0);
    check("rst_tick", 0, tick_cnt, 7'd0);
    check("rst_ready", 0, cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // RUN P=14 for 100 cycles
    issue(2'b01, 4'd14, 7'd0);
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      check("run14_shift", n, shift_en, ((n + 1) % 15) == 0);
      check("run14_flush", n, flush, 1'b0);
    end
    check("run14_tick", 99, tick_cnt, 7'd6);
    check("run14_busy", 99, busy, 1'b1);
    check("run14_ready", 99, cmd_ready, 1'b1);

    // BURST P=2 L=3 (accepted from RUN)
    issue(2'b10, 4'd2, 7'd3);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      check("b3_shift", n, shift_en, n == 2 || n == 5 || n == 8);
      check("b3_done", n, done, n == 9);
      check("b3_busy", n, busy, n < 9);
      check("b3_ready", n, cmd_ready, n >= 9);
      if (n == 0) check("b3_tick0", n, tick_cnt, 7'd0);
    end
    check("b3_tick", 11, tick_cnt, 7'd3);

    // FLUSH over 100 stages
    issue(2'b11, 4'd9, 7'd0);
    for (int n = 0; n < 102; n++) begin
      if (n > 0) @(negedge clk);
      check("fl_shift", n, shift_en, n < 100);
      check("fl_flush", n, flush, n < 100);
      check("fl_ready", n, cmd_ready, n >= 100);
      check("fl_done", n, done, n == 100);
      if (n == 100) check("fl_tick", n, tick_cnt, 7'd100);
    end

    // RUN P=0, STOP offered in cycle 5
    issue(2'b01, 4'd0, 7'd0);
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      check("p0_shift", n, shift_en, 1'b1);
    end
    issue(2'b00, 4'd0, 7'd0);
    for (int n = 6; n < 9; n++) begin
      if (n > 6) @(negedge clk);
      check("stop_shift", n, shift_en, 1'b0);
      check("stop_busy", n, busy, 1'b0);
      check("stop_done", n, done, 1'b0);
    end

    // BURST with L=0
    issue(2'b10, 4'd5, 7'd0);
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      check("l0_shift", n, shift_en, 1'b0);
      check("l0_busy", n, busy, 1'b0);
      check("l0_done", n, done, n == 1);
    end

    // BURST P=3 L=5 aborted by reset in cycle 6
    issue(2'b10, 4'd3, 7'd5);
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      check("ab_shift", n, shift_en, n == 3);
      check("ab_busy", n, busy, 1'b1);
    end
    check("ab_tick_pre", 6, tick_cnt, 7'd1);
    rst_n = 1'b0;
    #1;
    check("ab_rst_busy", 6, busy, 1'b0);
    check("ab_rst_shift", 6, shift_en, 1'b0);
    check("ab_rst_flush", 6, flush, 1'b0);
    check("ab_rst_done", 6, done, 1'b0);
    check("ab_rst_tick", 6, tick_cnt, 7'd0);
    check("ab_rst_ready", 6, cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 8; n < 30; n++) begin
      @(negedge clk);
      check("ab_done", n, done, 1'b0);
      check("ab_shift", n, shift_en, 1'b0);
    end

    // RUN P=7, then RUN P=1 accepted in cycle 4
    issue(2'b01, 4'd7, 7'd0);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      check("r7_shift", n, shift_en, 1'b0);
    end
    issue(2'b01, 4'd1, 7'd0);
    check("r1_tick0", 0, tick_cnt, 7'd0);
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      check("r1_shift", n, shift_en, (n % 2) == 1);
    end
    check("r1_tick", 6, tick_cnt, 7'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
